// File: rtl/uart_mmio.sv
// Memory-mapped UART slave: status, RX FIFO data, TX holding register and a
// free-running cycle counter, decoded in a 32-bit window at BASE_ADDR.
module uart_mmio #(
   parameter int          RX_DEPTH  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   localparam int PTR_W = $clog2(RX_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);

   // Register offsets within the window.
   localparam logic [31:0] OFS_STATUS  = 32'h0;
   localparam logic [31:0] OFS_RXDATA  = 32'h4;
   localparam logic [31:0] OFS_TXDATA  = 32'h8;
   localparam logic [31:0] OFS_COUNTER = 32'h10;
   localparam logic [31:0] OFS_CLEAR   = 32'h18;

   logic [7:0]       fifo_mem_q [RX_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             tx_full_q, tx_full_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [31:0]      cycle_q, cycle_d;
   logic [31:0]      rdata_q, rdata_d;

   logic sel_status, sel_rxdata, sel_txdata, sel_counter, sel_clear;
   logic rx_avail, push, pop, tx_hs, tx_load;

   // Upper store-data bits have no destination in this register map.
   logic unused_wdata_hi;
   assign unused_wdata_hi = ^wdata[31:8];

   // Exact-match address decode; anything else reads 0 and ignores stores.
   assign sel_status  = (addr == BASE_ADDR + OFS_STATUS);
   assign sel_rxdata  = (addr == BASE_ADDR + OFS_RXDATA);
   assign sel_txdata  = (addr == BASE_ADDR + OFS_TXDATA);
   assign sel_counter = (addr == BASE_ADDR + OFS_COUNTER);
   assign sel_clear   = (addr == BASE_ADDR + OFS_CLEAR);

   assign rx_avail      = (count_q != '0);
   assign uart_rx_ready = rst & (count_q != FULL_CNT);
   assign push          = uart_rx_valid & uart_rx_ready;
   assign pop           = re & sel_rxdata & rx_avail;
   // The tx_full check uses the pre-edge value, so a store racing the
   // handshake is dropped rather than overwriting the byte being sent.
   assign tx_hs         = tx_full_q & uart_tx_ready;
   assign tx_load       = we & sel_txdata & ~tx_full_q;

   assign uart_tx_valid = tx_full_q;
   assign uart_tx_data  = tx_data_q;
   assign rdata         = rdata_q;

   // Next-state logic for pointers, count, TX holding register, counter and load data.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      tx_full_d = tx_full_q;
      tx_data_d = tx_data_q;
      rdata_d   = rdata_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (tx_hs) begin
         tx_full_d = 1'b0;
      end else if (tx_load) begin
         tx_full_d = 1'b1;
         tx_data_d = wdata[7:0];
      end

      cycle_d = (we & sel_clear) ? 32'd0 : cycle_q + 32'd1;

      if (re) begin
         if (sel_status)       rdata_d = {30'b0, rx_avail, ~tx_full_q};
         else if (sel_rxdata)  rdata_d = rx_avail ? {24'b0, fifo_mem_q[rd_ptr_q]} : 32'd0;
         else if (sel_counter) rdata_d = cycle_q;
         else                  rdata_d = 32'd0;
      end
   end

   // Control and data state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         tx_full_q <= 1'b0;
         tx_data_q <= 8'd0;
         cycle_q   <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         tx_full_q <= tx_full_d;
         tx_data_q <= tx_data_d;
         cycle_q   <= cycle_d;
         rdata_q   <= rdata_d;
      end
   end

   // FIFO storage written on push.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count_q=0 marks it empty, so stale bytes are never read.
      if (push) fifo_mem_q[wr_ptr_q] <= uart_rx_data;
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio. Inputs change on the falling
// edge; outputs are sampled on the following falling edge.
module tb_uart_mmio;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int vectors = 0;
   int errors  = 0;

   uart_mmio #(.RX_DEPTH(4), .BASE_ADDR(BASE)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .wdata         (wdata),
      .we            (we),
      .re            (re),
      .rdata         (rdata),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Bus helpers: called at a falling edge, return at the next falling edge.
   task automatic do_load(input logic [31:0] a, output logic [31:0] d);
      addr = a; re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      d = rdata;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic do_push(input logic [7:0] b);
      uart_rx_data = b; uart_rx_valid = 1'b1;
      @(negedge clk);
      uart_rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
      uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (rdata !== 32'd0) begin
         $display("FAIL reset_rdata: got %h expected %h", rdata, 32'd0); errors++;
      end
      vectors++;
      if ({uart_tx_valid, uart_tx_data} !== 9'd0) begin
         $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", uart_tx_valid, uart_tx_data); errors++;
      end
      vectors++;
      if (uart_rx_ready !== 1'b0) begin
         $display("FAIL reset_rx_ready: got %b expected 0", uart_rx_ready); errors++;
      end
      uart_rx_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_status_empty;
      logic [31:0] d;
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL status_idle: got %h expected 1", d); errors++; end
      vectors++;
      if (uart_rx_ready !== 1'b1) begin $display("FAIL rx_ready_idle: got %b expected 1", uart_rx_ready); errors++; end
      do_load(BASE + 32'h4, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL rx_empty_read: got %h expected 0", d); errors++; end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL status_after_empty_pop: got %h expected 1", d); errors++; end
      // Unmapped addresses read 0; load data then holds while re is low.
      do_load(BASE + 32'h14, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL unmapped_read: got %h expected 0", d); errors++; end
      do_load(BASE + 32'h0, d);
      repeat (3) @(negedge clk);
      vectors++;
      if (rdata !== 32'h1) begin $display("FAIL rdata_hold: got %h expected 1", rdata); errors++; end
      do_store(BASE + 32'hC, 32'hFF);
      do_store(BASE + 32'h108, 32'hFF);
      vectors++;
      if (uart_tx_valid !== 1'b0) begin $display("FAIL unmapped_store: got valid %b expected 0", uart_tx_valid); errors++; end
   endtask

   task automatic test_rx_single;
      logic [31:0] d;
      do_push(8'h7A);
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h3) begin $display("FAIL rx_single_status: got %h expected 3", d); errors++; end
      do_load(BASE + 32'h4, d);
      vectors++;
      if (d !== 32'h7A) begin $display("FAIL rx_single_data: got %h expected 7a", d); errors++; end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL rx_single_drained: got %h expected 1", d); errors++; end
   endtask

   task automatic test_rx_full_wrap;
      logic [31:0] d;
      logic [7:0]  exp_bytes [4];
      exp_bytes[0] = 8'h22; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h44; exp_bytes[3] = 8'h55;
      do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44);
      vectors++;
      if (uart_rx_ready !== 1'b0) begin $display("FAIL fifo_full_ready: got %b expected 0", uart_rx_ready); errors++; end
      // Offer 0x55 and hold it across the pop.
      uart_rx_data = 8'h55; uart_rx_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (uart_rx_ready !== 1'b0) begin $display("FAIL fifo_full_hold: got %b expected 0", uart_rx_ready); errors++; end
      do_load(BASE + 32'h4, d);
      vectors++;
      if (d !== 32'h11) begin $display("FAIL full_pop_first: got %h expected 11", d); errors++; end
      vectors++;
      if (uart_rx_ready !== 1'b1) begin $display("FAIL ready_after_pop: got %b expected 1", uart_rx_ready); errors++; end
      @(negedge clk);
      uart_rx_valid = 1'b0;
      vectors++;
      if (uart_rx_ready !== 1'b0) begin $display("FAIL refilled_ready: got %b expected 0", uart_rx_ready); errors++; end
      for (int i = 0; i < 4; i++) begin
         do_load(BASE + 32'h4, d);
         vectors++;
         if (d !== {24'd0, exp_bytes[i]}) begin
            $display("FAIL wrap_pop_%0d: got %h expected %h", i, d, exp_bytes[i]); errors++;
         end
      end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL wrap_drained: got %h expected 1", d); errors++; end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      // Push and pop in one cycle with a single entry stored.
      do_push(8'h66);
      uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
      do_load(BASE + 32'h4, d);
      uart_rx_valid = 1'b0;
      vectors++;
      if (d !== 32'h66) begin $display("FAIL pushpop_old_head: got %h expected 66", d); errors++; end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h3) begin $display("FAIL pushpop_status: got %h expected 3", d); errors++; end
      do_load(BASE + 32'h4, d);
      vectors++;
      if (d !== 32'h77) begin $display("FAIL pushpop_new_head: got %h expected 77", d); errors++; end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL pushpop_drained: got %h expected 1", d); errors++; end
   endtask

   task automatic test_tx;
      logic [31:0] d;
      uart_tx_ready = 1'b0;
      do_store(BASE + 32'h8, 32'h0000_01A5);
      vectors++;
      if ({uart_tx_valid, uart_tx_data} !== {1'b1, 8'hA5}) begin
         $display("FAIL tx_load: got valid=%b data=%h expected 1/a5", uart_tx_valid, uart_tx_data); errors++;
      end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL tx_busy_status: got %h expected 0", d); errors++; end
      do_store(BASE + 32'h8, 32'h3C);
      vectors++;
      if (uart_tx_data !== 8'hA5) begin $display("FAIL tx_drop_when_full: got %h expected a5", uart_tx_data); errors++; end
      uart_tx_ready = 1'b1;
      @(negedge clk);
      uart_tx_ready = 1'b0;
      vectors++;
      if (uart_tx_valid !== 1'b0) begin $display("FAIL tx_handshake: got valid %b expected 0", uart_tx_valid); errors++; end
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL tx_free_status: got %h expected 1", d); errors++; end
      // A store in the handshake cycle is dropped.
      do_store(BASE + 32'h8, 32'h5A);
      uart_tx_ready = 1'b1;
      do_store(BASE + 32'h8, 32'h99);
      uart_tx_ready = 1'b0;
      vectors++;
      if (uart_tx_valid !== 1'b0) begin $display("FAIL tx_store_during_hs: got valid %b expected 0", uart_tx_valid); errors++; end
   endtask

   task automatic test_echo;
      logic [31:0] d;
      bit          seen;
      do_push(8'h7A);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         do_load(BASE + 32'h0, d);
         if (d[1]) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin $display("FAIL echo_poll: got rx_avail 0 expected 1 within 20 polls"); errors++; end
      do_load(BASE + 32'h4, d);
      do_store(BASE + 32'h8, d);
      vectors++;
      if ({uart_tx_valid, uart_tx_data} !== {1'b1, 8'h7A}) begin
         $display("FAIL echo_tx: got valid=%b data=%h expected 1/7a", uart_tx_valid, uart_tx_data); errors++;
      end
      uart_tx_ready = 1'b1;
      @(negedge clk);
      uart_tx_ready = 1'b0;
   endtask

   task automatic test_counter;
      logic [31:0] d;
      do_store(BASE + 32'h18, 32'hDEAD_BEEF);
      repeat (10) @(negedge clk);
      do_load(BASE + 32'h10, d);
      vectors++;
      if (d !== 32'd10) begin $display("FAIL counter_after_clear: got %0d expected 10", d); errors++; end
      do_load(BASE + 32'h10, d);
      vectors++;
      if (d !== 32'd11) begin $display("FAIL counter_increment: got %0d expected 11", d); errors++; end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      do_push(8'hA1);
      do_push(8'hB2);
      do_store(BASE + 32'h8, 32'hC3);
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h2) begin $display("FAIL pre_reset_status: got %h expected 2", d); errors++; end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({uart_tx_valid, uart_tx_data, uart_rx_ready, rdata} !== 42'd0) begin
         $display("FAIL async_reset: got valid=%b data=%h rx_ready=%b rdata=%h expected all 0",
                  uart_tx_valid, uart_tx_data, uart_rx_ready, rdata);
         errors++;
      end
      @(negedge clk);
      rst = 1'b1;
      do_load(BASE + 32'h0, d);
      vectors++;
      if (d !== 32'h1) begin $display("FAIL post_reset_status: got %h expected 1", d); errors++; end
      do_load(BASE + 32'h4, d);
      vectors++;
      if (d !== 32'h0) begin $display("FAIL post_reset_fifo: got %h expected 0", d); errors++; end
   endtask

   initial begin
      test_reset();
      test_status_empty();
      test_rx_single();
      test_rx_full_wrap();
      test_back_to_back();
      test_tx();
      test_echo();
      test_counter();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped I/O slave between the CPU's load/store path and the on-chip uart instance inside Riscv151.
- Decodes the 0x8000_00xx window and presents UART status, RX data, TX data and a cycle counter as 32-bit registers.
- Buffers received bytes in a small RX FIFO, so bytes arriving while software is busy are not lost.
- Holds one outgoing byte until the uart transmitter accepts it.

Parameters:
- RX_DEPTH, 4: RX FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h8000_0000: base of the register window.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the CPU memory stage.
- wdata  in  32  store data.
- we  in  1  store strobe, one cycle per store.
- re  in  1  load strobe, one cycle per load.
- rdata  out  32  registered load data.
- uart_tx_data  out  8  byte to the uart transmitter.
- uart_tx_valid  out  1  TX byte valid.
- uart_tx_ready  in  1  uart transmitter ready.
- uart_rx_data  in  8  byte from the uart receiver.
- uart_rx_valid  in  1  RX byte valid.
- uart_rx_ready  out  1  RX FIFO can accept a byte.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; tx_full=0; cycle counter=0.
  - rdata=0, uart_tx_data=0, uart_tx_valid=0.
  - uart_rx_ready is forced 0 while rst=0.
- Decode: exact 32-bit address match against BASE+0x0, 0x4, 0x8, 0x10, 0x18. Any other address: loads return 0, stores are ignored.
- Register map:
  - BASE+0x0 (read): {30'b0, rx_avail, tx_ready}; tx_ready=!tx_full, rx_avail=(count!=0).
  - BASE+0x4 (read): {24'b0, FIFO head}. Pops the head if non-empty. Empty: returns 0, no pop.
  - BASE+0x8 (write): wdata[7:0] loads the TX holding register and sets tx_full, only if tx_full=0 at that edge. Otherwise the write is dropped silently.
  - BASE+0x10 (read): 32-bit cycle counter.
  - BASE+0x18 (write): counter <= 0 at that edge; the data value is ignored.
- Load latency: rdata updates on the edge where re=1 and holds until the next re. Status and counter values are sampled before that edge's updates, so a counter read returns the pre-increment value.
- we and re may be asserted in the same cycle at different addresses; they act independently. A load of 0x4 and a store of 0x8 in one cycle are both performed.
- TX path:
  - uart_tx_valid = tx_full; uart_tx_data = holding register.
  - Handshake uart_tx_valid & uart_tx_ready clears tx_full at that edge.
  - A store to 0x8 in the same cycle as the handshake is dropped, because the tx_full=0 check uses the pre-edge value.
- RX path:
  - uart_rx_ready = (count != RX_DEPTH) when rst=1.
  - Push on uart_rx_valid & uart_rx_ready.
  - Push and pop in the same cycle: count unchanged and the head advances. With count==1 this is legal: the popped byte is the old head and the new byte becomes the head.
  - Full FIFO: no push; the uart receiver holds its byte until a pop frees an entry.
- Pointers are log2(RX_DEPTH) bits and wrap naturally. count is log2(RX_DEPTH)+1 bits.
- Cycle counter: +1 every cycle, wraps 0xFFFF_FFFF -> 0. A clear store takes priority over the increment.
- Reset mid-operation discards the FIFO contents and any pending TX byte immediately.

Test Plan:
- Reset, then load BASE+0x0 -> rdata=0x1 next cycle; load BASE+0x4 -> rdata=0, FIFO still empty.
- Drive uart_rx_valid with 0x7A for one handshake, load BASE+0x0 -> 0x3. Load BASE+0x4 -> 0x7A. Load BASE+0x0 -> 0x1.
- Push 0x11, 0x22, 0x33, 0x44 -> uart_rx_ready=0. Offer 0x55 and hold it -> not accepted. Pop -> 0x11, then 0x55 is accepted. Subsequent pops return 0x22, 0x33, 0x44, 0x55 in order, exercising pointer wrap.
- Store 0xA5 to BASE+0x8 with uart_tx_ready=0 -> uart_tx_valid=1, data 0xA5. Store 0x3C -> dropped. Raise uart_tx_ready for one cycle -> valid falls; status bit0 back to 1.
- Echo: RX byte 0x7A; bench polls status, loads 0x4, stores the result to 0x8 -> uart_tx_data=0x7A with uart_tx_valid=1.
- Store to BASE+0x18, wait 10 cycles, load BASE+0x10 -> 10. Assert rst low mid-transfer with FIFO count=2 and tx_full=1 -> all state clears asynchronously; status reads 0x1 after release.
